// File: rtl/id_ctrl_pkg.sv
// Shared encodings for the identifier arbiter: arbiter/recognizer states,
// character range bounds and small classification helpers.
package id_ctrl_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_S0   = 2'd1,
      ARB_S1   = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_LET  = 2'd1,
      R_DIG  = 2'd2
   } rec_state_e;

   localparam logic [7:0] CH_LA = 8'h61;  // 'a'
   localparam logic [7:0] CH_LZ = 8'h7A;  // 'z'
   localparam logic [7:0] CH_UA = 8'h41;  // 'A'
   localparam logic [7:0] CH_UZ = 8'h5A;  // 'Z'
   localparam logic [7:0] CH_D0 = 8'h30;  // '0'
   localparam logic [7:0] CH_D9 = 8'h39;  // '9'
   localparam logic [7:0] CNT_MAX = 8'd255;

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= CH_LA) && (c <= CH_LZ)) || ((c >= CH_UA) && (c <= CH_UZ));
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= CH_D0) && (c <= CH_D9);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/id_match_core.sv
// Identifier recognizer: classifies each accepted character and tracks
// whether the string so far is letters followed by digits.
module id_match_core
   import id_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] char_i,
   input  logic       en_i,
   input  logic       clr_i,
   output logic       is_dig_o
);

   rec_state_e state_q, state_d;

   // A digit only extends an identifier once a letter has been seen.
   always_comb begin
      state_d = state_q;
      if (clr_i) begin
         state_d = R_IDLE;
      end else if (en_i) begin
         if (is_letter(char_i)) begin
            state_d = R_LET;
         end else if (is_digit(char_i)) begin
            state_d = (state_q == R_IDLE) ? R_IDLE : R_DIG;
         end else begin
            state_d = R_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= R_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign is_dig_o = (state_q == R_DIG);

endmodule

// File: rtl/id_arb_ctrl.sv
// Two-requester round-robin arbiter that locks onto one string at a time,
// feeds it through the identifier recognizer and counts matches per source.
module id_arb_ctrl
   import id_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s0_valid,
   input  logic [7:0] s0_char,
   input  logic       s0_last,
   input  logic       s1_valid,
   input  logic [7:0] s1_char,
   input  logic       s1_last,
   output logic       s0_ready,
   output logic       s1_ready,
   output logic [1:0] gnt,
   output logic       res_valid,
   output logic       res_src,
   output logic       res_match,
   output logic [7:0] cnt0,
   output logic [7:0] cnt1
);

   arb_state_e arb_q, arb_d;
   logic       ptr_q, ptr_d;          // 0 favours s0, 1 favours s1
   logic       res_valid_q;
   logic       res_src_q;
   logic       res_match_q;
   logic [7:0] cnt_q [2];

   logic [7:0] sel_char;
   logic       sel_last;
   logic       hs;
   logic       last_hs;
   logic       core_dig;

   always_comb begin
      arb_d    = arb_q;
      ptr_d    = ptr_q;
      sel_char = (arb_q == ARB_S1) ? s1_char : s0_char;
      sel_last = (arb_q == ARB_S1) ? s1_last : s0_last;
      hs       = ((arb_q == ARB_S0) && s0_valid) || ((arb_q == ARB_S1) && s1_valid);
      last_hs  = hs && sel_last;
      case (arb_q)
         ARB_IDLE: begin
            if (s0_valid && s1_valid) begin
               arb_d = ptr_q ? ARB_S1 : ARB_S0;
            end else if (s0_valid) begin
               arb_d = ARB_S0;
            end else if (s1_valid) begin
               arb_d = ARB_S1;
            end
         end
         ARB_S0: begin
            if (last_hs) begin
               arb_d = ARB_IDLE;
               ptr_d = 1'b1;
            end
         end
         ARB_S1: begin
            if (last_hs) begin
               arb_d = ARB_IDLE;
               ptr_d = 1'b0;
            end
         end
         default: arb_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_q       <= ARB_IDLE;
         ptr_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_src_q   <= 1'b0;
         res_match_q <= 1'b0;
      end else begin
         arb_q       <= arb_d;
         ptr_q       <= ptr_d;
         res_valid_q <= last_hs;
         if (last_hs) begin
            res_src_q <= (arb_q == ARB_S1);
         end
         if (res_valid_q) begin
            res_match_q <= core_dig;
         end
      end
   end

   // The recognizer is cleared during the result cycle, when no requester
   // can be granted, so the next string always starts from R_IDLE.
   id_match_core u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .char_i   (sel_char),
      .en_i     (hs),
      .clr_i    (res_valid_q),
      .is_dig_o (core_dig)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q[gi] <= 8'd0;
            end else if (res_valid_q && core_dig && (res_src_q == gi[0])) begin
               cnt_q[gi] <= sat_inc(cnt_q[gi]);
            end
         end
      end
   endgenerate

   assign s0_ready  = (arb_q == ARB_S0);
   assign s1_ready  = (arb_q == ARB_S1);
   assign gnt       = {arb_q == ARB_S1, arb_q == ARB_S0};
   assign res_valid = res_valid_q;
   assign res_src   = res_src_q;
   assign res_match = res_valid_q ? core_dig : res_match_q;
   assign cnt0      = cnt_q[0];
   assign cnt1      = cnt_q[1];

endmodule

// File: tb/tb_id_arb_ctrl.sv
// Scoreboard bench for id_arb_ctrl: drivers push expected grants, characters
// and results into queues; a negedge monitor pops and compares them.
module tb_id_arb_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s0_valid, s0_last, s1_valid, s1_last;
   logic [7:0] s0_char, s1_char;
   logic       s0_ready, s1_ready;
   logic [1:0] gnt;
   logic       res_valid, res_src, res_match;
   logic [7:0] cnt0, cnt1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         src;
      logic [7:0] ch;
   } char_item_t;

   typedef struct {
      int src;
      bit m;
      int cnt;
   } res_item_t;

   char_item_t char_q[$];
   res_item_t  res_q[$];
   logic [1:0] gnt_q[$];

   always #5 clk = ~clk;

   id_arb_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s0_valid  (s0_valid),
      .s0_char   (s0_char),
      .s0_last   (s0_last),
      .s1_valid  (s1_valid),
      .s1_char   (s1_char),
      .s1_last   (s1_last),
      .s0_ready  (s0_ready),
      .s1_ready  (s1_ready),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_src   (res_src),
      .res_match (res_match),
      .cnt0      (cnt0),
      .cnt1      (cnt1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic [1:0] prev_gnt = 2'b00;
   bit         pend = 0;
   int         pend_src, pend_cnt;

   always @(negedge clk) begin
      char_item_t ci;
      res_item_t  ri;
      if (!rst_n) begin
         prev_gnt = 2'b00;
         pend     = 0;
      end else begin
         if (pend) begin
            chk("cnt_after_result", (pend_src == 0) ? cnt0 : cnt1, pend_cnt);
            $display("result cnt src=%0d cnt=%0d", pend_src, (pend_src == 0) ? cnt0 : cnt1);
            pend = 0;
         end
         if (gnt != 2'b00 && prev_gnt == 2'b00) begin
            if (gnt_q.size() == 0) chk("unexpected_grant", gnt, 2'b00);
            else chk("grant_order", gnt, gnt_q.pop_front());
         end
         prev_gnt = gnt;
         if (s0_valid && s0_ready && s1_valid && s1_ready) chk("dual_ready", 1, 0);
         if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) begin
            int         src;
            logic [7:0] ch;
            src = (s0_valid && s0_ready) ? 0 : 1;
            ch  = (src == 0) ? s0_char : s1_char;
            if (char_q.size() == 0) begin
               chk("unexpected_char", 1, 0);
            end else begin
               ci = char_q.pop_front();
               chk("char_src", src, ci.src);
               chk("char_val", ch, ci.ch);
            end
         end
         if (res_valid) begin
            if (res_q.size() == 0) begin
               chk("unexpected_result", res_valid, 0);
            end else begin
               ri = res_q.pop_front();
               chk("res_src", res_src, ri.src);
               chk("res_match", res_match, ri.m);
               $display("result src=%0d match=%0d", res_src, res_match);
               pend     = 1;
               pend_src = ri.src;
               pend_cnt = ri.cnt;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic expect_str(input int src, input string s, input bit m, input int ec,
                             input bit with_last);
      char_item_t ci;
      res_item_t  ri;
      gnt_q.push_back((src == 0) ? 2'b01 : 2'b10);
      for (int i = 0; i < s.len(); i++) begin
         ci.src = src;
         ci.ch  = s[i];
         char_q.push_back(ci);
      end
      if (with_last) begin
         ri.src = src;
         ri.m   = m;
         ri.cnt = ec;
         res_q.push_back(ri);
      end
   endtask

   task automatic wait_hs(input int src);
      int tries;
      bit rdy;
      tries = 0;
      rdy   = 0;
      while (!rdy && tries < 300) begin
         @(negedge clk);
         rdy = (src == 0) ? s0_ready : s1_ready;
         @(posedge clk);
         tries++;
      end
      #1;
      if (!rdy) begin
         total++;
         bad++;
         $display("FAIL hs_timeout src=%0d actual=no_ready required=ready", src);
      end
   endtask

   task automatic send_str(input int src, input string s, input bit with_last);
      bit lst;
      for (int i = 0; i < s.len(); i++) begin
         lst = with_last && (i == s.len() - 1);
         if (src == 0) begin
            s0_valid = 1'b1; s0_char = s[i]; s0_last = lst;
         end else begin
            s1_valid = 1'b1; s1_char = s[i]; s1_last = lst;
         end
         wait_hs(src);
      end
      if (src == 0) begin
         s0_valid = 1'b0; s0_last = 1'b0;
      end else begin
         s1_valid = 1'b0; s1_last = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      idle(2);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      string s0_list[3];
      string s1_list[3];
      rst_n    = 1'b0;
      s0_valid = 1'b0; s0_char = 8'h00; s0_last = 1'b0;
      s1_valid = 1'b0; s1_char = 8'h00; s1_last = 1'b0;
      idle(2);
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_ready", {s0_ready, s1_ready}, 2'b00);
      chk("rst_res", {res_valid, res_src, res_match}, 3'b000);
      chk("rst_cnt", {cnt0, cnt1}, 16'h0000);
      rst_n = 1'b1;
      idle(2);

      // s0 "ab12" matches; ready appears one cycle after valid
      expect_str(0, "ab12", 1, 1, 1);
      fork
         send_str(0, "ab12", 1);
         begin
            @(negedge clk);
            chk("ready_lat0", s0_ready, 1'b0);
            @(negedge clk);
            chk("ready_lat1", s0_ready, 1'b1);
            chk("gnt_s0", gnt, 2'b01);
         end
      join
      idle(4);
      $display("txn s0 ab12 cnt0=%0d", cnt0);

      // s1 non-identifiers
      expect_str(1, "a1b", 0, 0, 1); send_str(1, "a1b", 1); idle(3);
      expect_str(1, "12",  0, 0, 1); send_str(1, "12",  1); idle(3);
      expect_str(1, "a_1", 0, 0, 1); send_str(1, "a_1", 1); idle(3);
      chk("cnt1_unchanged", cnt1, 8'd0);

      // partial string aborted by reset mid-operation, then clean "c3"
      expect_str(0, "ab", 0, 0, 0);
      send_str(0, "ab", 0);
      idle(2);
      chk("midop_gnt", gnt, 2'b01);
      rst_n = 1'b0;
      #1;
      chk("async_gnt", gnt, 2'b00);
      chk("async_ready", {s0_ready, s1_ready}, 2'b00);
      chk("async_res", {res_valid, res_src, res_match}, 3'b000);
      chk("async_cnt", {cnt0, cnt1}, 16'h0000);
      #1;
      rst_n = 1'b1;
      idle(2);
      expect_str(0, "c3", 1, 1, 1);
      send_str(0, "c3", 1);
      idle(4);
      $display("txn s0 c3 after reset cnt0=%0d", cnt0);

      // both requesters from idle: alternate s0,s1 per string, no interleave
      pulse_reset();
      s0_list = '{"ab12", "x", "q7"};
      s1_list = '{"9", "a1", "zz"};
      expect_str(0, s0_list[0], 1, 1, 1);
      expect_str(1, s1_list[0], 0, 0, 1);
      expect_str(0, s0_list[1], 0, 1, 1);
      expect_str(1, s1_list[1], 1, 1, 1);
      expect_str(0, s0_list[2], 1, 2, 1);
      expect_str(1, s1_list[2], 0, 1, 1);
      fork
         for (int i = 0; i < 3; i++) send_str(0, s0_list[i], 1);
         for (int i = 0; i < 3; i++) send_str(1, s1_list[i], 1);
      join
      idle(4);
      $display("txn round-robin cnt0=%0d cnt1=%0d", cnt0, cnt1);

      // saturation
      pulse_reset();
      for (int k = 0; k < 260; k++) expect_str(0, "z9", 1, (k + 1 > 255) ? 255 : k + 1, 1);
      for (int k = 0; k < 260; k++) send_str(0, "z9", 1);
      idle(4);
      chk("cnt0_saturated", cnt0, 8'd255);
      $display("txn saturation cnt0=%0d", cnt0);

      chk("res_queue_empty", res_q.size(), 0);
      chk("char_queue_empty", char_q.size(), 0);
      chk("gnt_queue_empty", gnt_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_arb_ctrl.md
ID_ARB_CTRL -- requirements
Module: id_arb_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: s0_valid / s1_valid  input  1  requester char valid.
REQ-004 SHALL have ports: s0_char / s1_char  input  8  ASCII character.
REQ-005 SHALL have ports: s0_last / s1_last  input  1  final char of string.
REQ-006 SHALL have ports: s0_ready / s1_ready  output  1  char accepted when valid&&ready.
REQ-007 SHALL have port: gnt  output  2  one-hot current owner, 2'b00 when idle.
REQ-008 SHALL have ports: res_valid  output  1  one-cycle result pulse; res_src  output  1  requester index; res_match  output  1  string is identifier.
REQ-009 SHALL have ports: cnt0 / cnt1  output  8  per-requester match count.

Function
REQ-010 SHALL arbitrate with FSM states ARB_IDLE, ARB_S0, ARB_S1; ready = (state==ARB_Sx), gnt mirrors state.
REQ-011 SHALL, in ARB_IDLE with any valid, move to the granted state next cycle; ready not asserted in ARB_IDLE (grant latency 1 cycle).
REQ-012 SHALL resolve simultaneous valids by round-robin pointer: favour requester not served last; pointer resets to favour s0.
REQ-013 SHALL hold grant for a whole string (lock) until last handshake; valid low mid-string keeps grant and recognizer state.
REQ-014 SHALL, on last handshake, return to ARB_IDLE next cycle and toggle pointer to the other requester.
REQ-015 SHALL classify each accepted char: letter = 'a'-'z','A'-'Z'; digit = '0'-'9'; other = everything else.
REQ-016 SHALL recognize with states R_IDLE, R_LET, R_DIG: letter -> R_LET from any state; digit: R_IDLE -> R_IDLE, R_LET/R_DIG -> R_DIG; other -> R_IDLE.
REQ-017 SHALL define string match = recognizer state after last char is R_DIG (letters then digits, e.g. "ab12", "x1y2").
REQ-018 SHALL force recognizer to R_IDLE on the cycle after each last handshake, so each string starts clean.
REQ-019 SHALL pulse res_valid for exactly one cycle, the cycle after the last handshake, with res_src/res_match valid in that cycle; res_src/res_match hold otherwise.
REQ-020 SHALL increment cnt of res_src on each match, saturating at 8'd255.
REQ-021 SHALL treat single-char strings (valid+last on first char) normally; never produce result without a last handshake.
REQ-022 SHALL ignore the non-granted requester's inputs entirely.

Reset
REQ-023 SHALL, on rst_n low, asynchronously set ARB_IDLE, R_IDLE, pointer=s0, s0_ready=s1_ready=0, gnt=0, res_valid=res_src=res_match=0, cnt0=cnt1=0.
REQ-024 SHALL discard any partially received string on reset; no result emitted for it.

Structure
REQ-025 SHALL keep ARB_* and R_* state encodings and char range constants in shared package id_ctrl_pkg.
REQ-026 SHALL place recognizer (char classify + R_* FSM, inputs char/en/clr, output is_dig state) in sub-module id_match_core; arbiter, pointer, counters in top.

Verification
REQ-027 SHALL test reset: rst_n=0 mid-operation -> all outputs 0 immediately, cnt0=cnt1=0.
REQ-028 SHALL test s0 sends "ab12" (last on '2') -> s0_ready high 1 cycle after s0_valid; res_valid pulse, res_src=0, res_match=1, cnt0=1.
REQ-029 SHALL test s1 strings "a1b", "12", "a_1" -> each res_src=1, res_match=0, cnt1 unchanged 0.
REQ-030 SHALL test both valid from idle after reset with 3 strings each -> grants ordered s0,s1,s0,s1,s0,s1; no char interleaving.
REQ-031 SHALL test 260 matching strings "z9" on s0 -> cnt0 stops at 255.
REQ-032 SHALL test rst_n pulse after "ab" on s0, then s0 "c3" -> single res_valid, res_match=1, cnt0=1.
